// File: rtl/cmd_arbiter_pkg.sv
// Shared types and constants for the UART command arbiter.
// The response timeout is enabled by defining CMD_ARBITER_TIMEOUT_EN.
package cmd_arbiter_pkg;

    localparam int CMD_W = 16;
    localparam int RESP_W = 8;
    localparam logic [RESP_W-1:0] TIMEOUT_RESP = 8'h00;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_TX   = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } cmd_arb_state_t;

endpackage

// File: rtl/cmd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1,
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] sel,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [PTR_W-1:0] pos_s;
    logic             hit_s;

    // Priority scan; the first hit after ptr wins and masks all later candidates.
    always_comb begin
        sel   = '0;
        idx   = '0;
        any   = 1'b0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s      = PTR_W'((int'(ptr) + k) % NUM_REQ);
            hit_s      = ~any & req[pos_s];
            sel[pos_s] = hit_s;
            idx        = hit_s ? pos_s : idx;
            any        = any | hit_s;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART command master between NUM_REQ requesters.
// Optional response timeout: define CMD_ARBITER_TIMEOUT_EN.
module cmd_arbiter
    import cmd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [CMD_W*NUM_REQ-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [RESP_W-1:0]          resp,
    output logic                       resp_err,
    output logic                       snd_cmd,
    output logic [CMD_W-1:0]           cmd,
    input  logic                       cmd_cmplt,
    input  logic [RESP_W-1:0]          response,
    input  logic                       response_cmplt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    cmd_arb_state_t      state_r, state_nxt_s;
    logic [PTR_W-1:0]    ptr_r, pick_idx_s;
    logic [NUM_REQ-1:0]  pick_sel_s;
    logic                pick_any_s;
    logic [CMD_W-1:0]    pick_cmd_s;
    logic                rc_prev_r, rise_s, pend_r;
    logic [RESP_W-1:0]   byte_r;
    logic                tmo_s;

`ifdef CMD_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_r;
    logic             err_r, resp_err_r;

    assign tmo_s    = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    assign resp_err = resp_err_r;
`else
    assign tmo_s    = 1'b0;
    assign resp_err = 1'b0;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req (req),
        .ptr (ptr_r),
        .sel (pick_sel_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    assign rise_s     = response_cmplt & ~rc_prev_r;
    assign pick_cmd_s = req_cmd[int'(pick_idx_s) * CMD_W +: CMD_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a timeout in WAIT_TX beats a simultaneous cmd_cmplt so it cannot be skipped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) state_nxt_s = ISSUE;
                else            state_nxt_s = IDLE;
            end
            ISSUE: state_nxt_s = WAIT_TX;
            WAIT_TX: begin
                if (tmo_s)          state_nxt_s = DONE;
                else if (cmd_cmplt) state_nxt_s = WAIT_RESP;
                else                state_nxt_s = WAIT_TX;
            end
            WAIT_RESP: begin
                if (pend_r || rise_s || tmo_s) state_nxt_s = DONE;
                else                           state_nxt_s = WAIT_RESP;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant, command, response capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r     <= PTR_W'(NUM_REQ - 1);
            grant     <= '0;
            done      <= '0;
            resp      <= 8'h00;
            snd_cmd   <= 1'b0;
            cmd       <= 16'h0000;
            rc_prev_r <= 1'b0;
            pend_r    <= 1'b0;
            byte_r    <= 8'h00;
`ifdef CMD_ARBITER_TIMEOUT_EN
            cnt_r      <= '0;
            err_r      <= 1'b0;
            resp_err_r <= 1'b0;
`endif
        end else begin
            rc_prev_r <= response_cmplt;
            snd_cmd   <= 1'b0;
            done      <= '0;
            case (state_r)
                IDLE: begin
                    pend_r <= 1'b0;
                    if (pick_any_s) begin
                        grant   <= pick_sel_s;
                        ptr_r   <= pick_idx_s;
                        cmd     <= pick_cmd_s;
                        snd_cmd <= 1'b1;
                    end
                end
                ISSUE: begin
`ifdef CMD_ARBITER_TIMEOUT_EN
                    cnt_r <= '0;
                    err_r <= 1'b0;
`endif
                end
                WAIT_TX: begin
                    // An early response is remembered so WAIT_RESP can finish at once.
                    if (rise_s) begin
                        pend_r <= 1'b1;
                        byte_r <= response;
                    end
`ifdef CMD_ARBITER_TIMEOUT_EN
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (tmo_s) begin
                        byte_r <= TIMEOUT_RESP;
                        err_r  <= 1'b1;
                    end
`endif
                end
                WAIT_RESP: begin
                    if (pend_r) begin
                        pend_r <= 1'b0;
                    end else if (rise_s) begin
                        byte_r <= response;
                    end else if (tmo_s) begin
                        byte_r <= TIMEOUT_RESP;
`ifdef CMD_ARBITER_TIMEOUT_EN
                        err_r  <= 1'b1;
`endif
                    end
`ifdef CMD_ARBITER_TIMEOUT_EN
                    cnt_r <= cnt_r + CNT_W'(1);
`endif
                end
                DONE: begin
                    done   <= NUM_REQ'(1) << ptr_r;
                    grant  <= '0;
                    resp   <= byte_r;
                    pend_r <= 1'b0;
`ifdef CMD_ARBITER_TIMEOUT_EN
                    resp_err_r <= err_r;
`endif
                end
                default: begin
                    grant  <= '0;
                    pend_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed scenarios plus randomized transactions
// compared against a round-robin reference model.
module tb_cmd_arbiter;

    localparam int N = 4;
`ifdef CMD_ARBITER_TIMEOUT_EN
    localparam int TCYC = 64;
`else
    localparam int TCYC = 1_000_000;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [16*N-1:0] req_cmd = '0;
    logic [N-1:0]    grant, done;
    logic [7:0]      resp;
    logic            resp_err, snd_cmd;
    logic [15:0]     cmd;
    logic            cmd_cmplt = 1'b0;
    logic [7:0]      response = 8'h00;
    logic            response_cmplt = 1'b0;

    int checks = 0;
    int failures = 0;
    int m_ptr = N - 1;
    logic [15:0] m_cmd [N];

    cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .grant(grant), .done(done),
        .resp(resp), .resp_err(resp_err), .snd_cmd(snd_cmd), .cmd(cmd),
        .cmd_cmplt(cmd_cmplt), .response(response), .response_cmplt(response_cmplt)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule: first requester after the last winner, wrapping around.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] c);
        m_cmd[i] = c;
        req_cmd[16*i +: 16] = c;
        req[i] = 1'b1;
    endtask

    task automatic wait_issue(output bit ok, output logic [N-1:0] g, output logic [15:0] c);
        ok = 1'b0; g = '0; c = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (snd_cmd === 1'b1) begin
                ok = 1'b1; g = grant; c = cmd;
                return;
            end
        end
    endtask

    // Plays the command master for one transaction; step 0 starts in the ISSUE cycle.
    task automatic respond(input int t, input int gap, input bit early, input logic [7:0] b,
                           input bit drop, output bit ok, output logic [N-1:0] d,
                           output logic [7:0] r, output logic e, output int step,
                           output int snd_seen);
        int rise;
        rise = early ? t : t + 1 + gap;
        ok = 1'b0; d = '0; r = '0; e = 1'b0; step = -1; snd_seen = 0;
        for (int s = 0; s < 40; s++) begin
            cmd_cmplt      = (s == t);
            response_cmplt = (s >= rise);
            response       = (s == rise) ? b : 8'($urandom);
            tick();
            if (snd_cmd === 1'b1) snd_seen++;
            if (done !== '0) begin
                ok = 1'b1; d = done; r = resp; e = resp_err; step = s;
                if (drop) req = req & ~done;
                cmd_cmplt = 1'b0;
                return;
            end
        end
        cmd_cmplt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (resp !== 8'h00) begin failures++; $display("FAIL reset_resp: got %h want 00", resp); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        checks++; if (snd_cmd !== 1'b0) begin failures++; $display("FAIL reset_snd_cmd: got %b want 0", snd_cmd); end
        checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
        rst = 1'b0;
        m_ptr = N - 1;
    endtask

    task automatic test_single();
        bit ok; logic [N-1:0] g, d; logic [15:0] c; logic [7:0] r; logic e; int st, sn, exp;
        set_req(0, 16'hA53C);
        exp = model_pick(req, m_ptr);
        wait_issue(ok, g, c);
        checks++; if (!ok || g !== onehot(exp)) begin failures++; $display("FAIL single_grant: got %b want %b", g, onehot(exp)); end
        checks++; if (c !== 16'hA53C) begin failures++; $display("FAIL single_cmd: got %h want a53c", c); end
        m_ptr = exp;
        respond(2, 1, 1'b0, 8'hA5, 1'b1, ok, d, r, e, st, sn);
        checks++; if (!ok || d !== 4'b0001) begin failures++; $display("FAIL single_done: got %b want 0001", d); end
        checks++; if (r !== 8'hA5 || e !== 1'b0) begin failures++; $display("FAIL single_resp: got %h/%b want a5/0", r, e); end
        checks++; if (st !== 5 || sn !== 0) begin failures++; $display("FAIL single_timing: step %0d snd %0d want 5 0", st, sn); end
        response_cmplt = 1'b0;
    endtask

    task automatic test_fairness();
        bit ok; logic [N-1:0] g, d; logic [15:0] c; logic [7:0] r, b; logic e; int st, sn, exp;
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom));
        for (int n = 0; n < 5; n++) begin
            exp = model_pick(req, m_ptr);
            wait_issue(ok, g, c);
            checks++; if (!ok || g !== onehot(exp) || c !== m_cmd[exp]) begin failures++; $display("FAIL fair_grant%0d: got %b/%h want %b/%h", n, g, c, onehot(exp), m_cmd[exp]); end
            m_ptr = exp;
            b = 8'($urandom);
            respond(1, $urandom_range(0, 2), 1'b0, b, 1'b0, ok, d, r, e, st, sn);
            checks++; if (!ok || d !== onehot(exp) || r !== b || sn !== 0) begin failures++; $display("FAIL fair_done%0d: got %b/%h snd %0d want %b/%h", n, d, r, sn, onehot(exp), b); end
        end
        req = '0;
        response_cmplt = 1'b0;
    endtask

    task automatic test_held();
        bit ok; logic [N-1:0] g, d; logic [15:0] c; logic [7:0] r; logic e; int st, sn, exp, extra;
        set_req(2, 16'h1357);
        exp = model_pick(req, m_ptr);
        wait_issue(ok, g, c);
        checks++; if (!ok || g !== onehot(exp)) begin failures++; $display("FAIL held_grant1: got %b want %b", g, onehot(exp)); end
        m_ptr = exp;
        respond(1, 0, 1'b0, 8'h3C, 1'b1, ok, d, r, e, st, sn);
        checks++; if (!ok || d !== onehot(exp) || r !== 8'h3C || st !== 3) begin failures++; $display("FAIL held_done1: got %b/%h step %0d want %b/3c step 3", d, r, st, onehot(exp)); end
        set_req(2, 16'h2468);
        exp = model_pick(req, m_ptr);
        wait_issue(ok, g, c);
        checks++; if (!ok || g !== onehot(exp) || c !== 16'h2468) begin failures++; $display("FAIL held_grant2: got %b/%h want %b/2468", g, c, onehot(exp)); end
        m_ptr = exp;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_cmplt = (i == 1);
            response_cmplt = (i < 3);
            response = 8'($urandom);
            tick();
            if (done !== '0) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL held_level_once: got %0d done pulses want 0", extra); end
        respond(1, 0, 1'b0, 8'h5A, 1'b1, ok, d, r, e, st, sn);
        checks++; if (!ok || d !== onehot(exp) || r !== 8'h5A || st !== 3) begin failures++; $display("FAIL held_done2: got %b/%h step %0d want %b/5a step 3", d, r, st, onehot(exp)); end
        response_cmplt = 1'b0;
    endtask

    task automatic test_early();
        bit ok; logic [N-1:0] g, d; logic [15:0] c; logic [7:0] r; logic e; int st, sn, exp;
        set_req(1, 16'($urandom));
        exp = model_pick(req, m_ptr);
        wait_issue(ok, g, c);
        checks++; if (!ok || g !== onehot(exp) || c !== m_cmd[exp]) begin failures++; $display("FAIL early_grant: got %b/%h want %b/%h", g, c, onehot(exp), m_cmd[exp]); end
        m_ptr = exp;
        respond(2, 0, 1'b1, 8'hC3, 1'b1, ok, d, r, e, st, sn);
        checks++; if (!ok || d !== onehot(exp) || r !== 8'hC3 || st !== 4) begin failures++; $display("FAIL early_done: got %b/%h step %0d want %b/c3 step 4", d, r, st, onehot(exp)); end
        response_cmplt = 1'b0;
    endtask

    task automatic test_random();
        bit ok, early; logic [N-1:0] g, d; logic [15:0] c; logic [7:0] r, b; logic e;
        int st, sn, exp, t, gap, bits;
        for (int n = 0; n < 20; n++) begin
            bits = $urandom_range(1, (1 << N) - 1);
            for (int i = 0; i < N; i++) begin
                if (bits[i] && !req[i]) set_req(i, 16'($urandom));
            end
            exp = model_pick(req, m_ptr);
            wait_issue(ok, g, c);
            checks++; if (!ok || g !== onehot(exp) || c !== m_cmd[exp]) begin failures++; $display("FAIL rand_grant%0d: got %b/%h want %b/%h", n, g, c, onehot(exp), m_cmd[exp]); end
            m_ptr = exp;
            t = $urandom_range(1, 4);
            gap = $urandom_range(0, 3);
            early = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            respond(t, gap, early, b, 1'b1, ok, d, r, e, st, sn);
            checks++;
            if (!ok || d !== onehot(exp) || r !== b || e !== 1'b0 || sn !== 0 ||
                st !== (early ? t + 2 : t + gap + 2)) begin
                failures++;
                $display("FAIL rand_done%0d: got %b/%h/%b step %0d want %b/%h/0 step %0d", n, d, r, e, st, onehot(exp), b, early ? t + 2 : t + gap + 2);
            end
            response_cmplt = 1'b0;
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        bit ok; logic [N-1:0] g, d; logic [15:0] c; logic [7:0] r; logic e; int st, sn, exp, extra;
        set_req(2, 16'($urandom));
        wait_issue(ok, g, c);
        for (int i = 0; i < 2; i++) begin
            cmd_cmplt = (i == 1);
            tick();
        end
        cmd_cmplt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = N - 1;
        checks++; if (grant !== '0 || done !== '0 || snd_cmd !== 1'b0) begin failures++; $display("FAIL rstmid_clear: grant %b done %b snd %b want 0", grant, done, snd_cmd); end
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom));
        response_cmplt = 1'b1;
        response = 8'hEE;
        exp = model_pick(req, m_ptr);
        wait_issue(ok, g, c);
        checks++; if (!ok || g !== onehot(exp) || exp !== 0) begin failures++; $display("FAIL rstmid_first: got %b want 0001", g); end
        m_ptr = exp;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_cmplt = (i == 1);
            tick();
            if (done !== '0) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL rstmid_stale: got %0d done pulses want 0", extra); end
        respond(1, 0, 1'b0, 8'h69, 1'b1, ok, d, r, e, st, sn);
        req = '0;
        checks++; if (!ok || d !== 4'b0001 || r !== 8'h69 || st !== 3) begin failures++; $display("FAIL rstmid_done: got %b/%h step %0d want 0001/69 step 3", d, r, st); end
        response_cmplt = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok; logic [N-1:0] g; logic [15:0] c; int exp, seen, at;
        set_req(3, 16'($urandom));
        exp = model_pick(req, m_ptr);
        wait_issue(ok, g, c);
        checks++; if (!ok || g !== onehot(exp)) begin failures++; $display("FAIL tmo_grant: got %b want %b", g, onehot(exp)); end
        m_ptr = exp;
        seen = 0; at = -1;
`ifdef CMD_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 100 && seen == 0; i++) begin
            tick();
            if (done !== '0) begin
                seen = 1; at = i;
                checks++; if (done !== onehot(exp) || resp_err !== 1'b1 || resp !== 8'h00) begin failures++; $display("FAIL tmo_done: got %b/%b/%h want %b/1/00", done, resp_err, resp); end
                req = '0;
            end
        end
        checks++; if (seen == 0 || at < 60 || at > 70) begin failures++; $display("FAIL tmo_latency: got cycle %0d want about 64", at); end
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (done !== '0) seen++;
        end
        checks++; if (seen !== 0 || grant !== onehot(exp)) begin failures++; $display("FAIL tmo_wait: got %0d done grant %b want 0 %b", seen, grant, onehot(exp)); end
        req = '0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = N - 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_held();
        test_early();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
